// File: rtl/zbuf_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : zbuf_pixel_scheduler
// Purpose  : Arbitrates four pixel FIFOs onto the single Z-buffer write port.
//            A source that has lost AGE_MAX rounds in a row is served first.
//            Otherwise the fullest FIFO wins. Each grant moves up to BURST
//            pixels through a req/ack pop followed by a send/rdy push.
// Ports    : clk, rst_n                 clock, async active-low reset
//            fill_1..4, pix_in_1..4     FIFO fill levels and head pixels
//            ack_1..4 / req_1..4        FIFO pop handshake
//            rdy_z_buffer/send_z_buffer Z-buffer valid/ready handshake
//            pix_out                    pixel presented to the Z-buffer
//            grant_id                   current/last granted FIFO (0..3)
//            busy, timeout_err          status, ack-timeout pulse
// Revision : 1.0  initial release
// ============================================================================
module zbuf_pixel_scheduler #(
  parameter int LENGTH      = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int BURST       = 4,
  parameter int AGE_MAX     = 15,
  parameter int TIMEOUT     = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LENGTH-1:0]      fill_1,
  input  logic [LENGTH-1:0]      fill_2,
  input  logic [LENGTH-1:0]      fill_3,
  input  logic [LENGTH-1:0]      fill_4,
  input  logic [PIXEL_WIDTH-1:0] pix_in_1,
  input  logic [PIXEL_WIDTH-1:0] pix_in_2,
  input  logic [PIXEL_WIDTH-1:0] pix_in_3,
  input  logic [PIXEL_WIDTH-1:0] pix_in_4,
  input  logic                   ack_1,
  input  logic                   ack_2,
  input  logic                   ack_3,
  input  logic                   ack_4,
  output logic                   req_1,
  output logic                   req_2,
  output logic                   req_3,
  output logic                   req_4,
  input  logic                   rdy_z_buffer,
  output logic                   send_z_buffer,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int AW = $clog2(AGE_MAX + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] AGE_LIMIT = AW'(AGE_MAX);
  localparam logic [AW-1:0] AGE_ONE   = AW'(1);
  localparam logic [BW-1:0] BEAT_LIM  = BW'(BURST);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_REQ  = 2'd2,
    S_SEND = 2'd3
  } state_t;

  // Per-source views of the flat port list
  logic [LENGTH-1:0]      fill_w [4];
  logic [PIXEL_WIDTH-1:0] pix_w  [4];
  logic [3:0]             ack_w;
  logic [3:0]             nonempty_w;

  assign fill_w[0] = fill_1;
  assign fill_w[1] = fill_2;
  assign fill_w[2] = fill_3;
  assign fill_w[3] = fill_4;
  assign pix_w[0]  = pix_in_1;
  assign pix_w[1]  = pix_in_2;
  assign pix_w[2]  = pix_in_3;
  assign pix_w[3]  = pix_in_4;
  assign ack_w     = {ack_4, ack_3, ack_2, ack_1};

  // Registered state
  state_t           state_q;
  logic [1:0]       grant_q;
  logic [3:0]       req_q;
  logic             send_q;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic             busy_q;
  logic             timeout_q;
  logic [BW-1:0]    beats_q;
  logic [WW-1:0]    wait_q;
  logic [AW-1:0]    age_q [4];

  // Winner selection
  logic [1:0]        aged_win_w;
  logic              aged_found_w;
  logic [1:0]        fill_win_w;
  logic [LENGTH-1:0] best_fill_w;
  logic [1:0]        win_w;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty_w[i] = (fill_w[i] != '0);
    end

    // Descending scan so the lowest starving index is the one left standing
    aged_found_w = 1'b0;
    aged_win_w   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (nonempty_w[i] && (age_q[i] == AGE_LIMIT)) begin
        aged_found_w = 1'b1;
        aged_win_w   = 2'(i);
      end
    end

    // Strict compare keeps ties on the lowest index
    best_fill_w = fill_w[0];
    fill_win_w  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (fill_w[i] > best_fill_w) begin
        best_fill_w = fill_w[i];
        fill_win_w  = 2'(i);
      end
    end

    win_w = aged_found_w ? aged_win_w : fill_win_w;
  end

  // Signals of the currently granted source
  logic                   ack_g_w;
  logic [LENGTH-1:0]      fill_g_w;
  logic [PIXEL_WIDTH-1:0] pix_g_w;

  assign ack_g_w  = ack_w[grant_q];
  assign fill_g_w = fill_w[grant_q];
  assign pix_g_w  = pix_w[grant_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'd0;
      req_q     <= 4'b0000;
      send_q    <= 1'b0;
      pix_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      beats_q   <= '0;
      wait_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|nonempty_w) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
          end
        end

        S_ARB: begin
          grant_q <= win_w;
          beats_q <= '0;
          wait_q  <= '0;
          req_q   <= 4'b0001 << win_w;
          state_q <= S_REQ;
          // Losers that still hold pixels age; empty sources keep their age
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == win_w) begin
              age_q[i] <= '0;
            end else if (nonempty_w[i] && (age_q[i] != AGE_LIMIT)) begin
              age_q[i] <= age_q[i] + AGE_ONE;
            end
          end
        end

        S_REQ: begin
          if (ack_g_w) begin
            pix_q   <= pix_g_w;
            send_q  <= 1'b1;
            req_q   <= 4'b0000;
            beats_q <= beats_q + BEAT_ONE;
            state_q <= S_SEND;
          end else if (wait_q == WAIT_LAST) begin
            // Abandon the grant; the source's age was already cleared at ARB
            req_q     <= 4'b0000;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            wait_q <= wait_q + WAIT_ONE;
          end
        end

        S_SEND: begin
          // No timeout here: a stalled Z-buffer simply holds the pixel
          if (rdy_z_buffer) begin
            send_q <= 1'b0;
            if ((beats_q < BEAT_LIM) && (fill_g_w != '0)) begin
              wait_q  <= '0;
              req_q   <= 4'b0001 << grant_q;
              state_q <= S_REQ;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_1         = req_q[0];
  assign req_2         = req_q[1];
  assign req_3         = req_q[2];
  assign req_4         = req_q[3];
  assign send_z_buffer = send_q;
  assign pix_out       = pix_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_zbuf_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_zbuf_pixel_scheduler
// Purpose  : Self-checking bench for zbuf_pixel_scheduler. Directed scenarios
//            plus a randomized run against a transaction-level model of the
//            arbitration and burst rules. A second instance with BURST=1
//            covers the starvation guard.
// Revision : 1.0  initial release
// ============================================================================
module tb_zbuf_pixel_scheduler;

  localparam int LENGTH  = 8;
  localparam int PW      = 8;
  localparam int BURST   = 4;
  localparam int AGE_MAX = 15;
  localparam int TIMEOUT = 7;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance
  logic [LENGTH-1:0] fill   [4];
  logic [PW-1:0]     pix_in [4];
  logic [3:0]        ack;
  logic              rdy;
  wire  [3:0]        req_w;
  wire               send;
  wire  [PW-1:0]     pix_out;
  wire  [1:0]        grant_id;
  wire               busy;
  wire               terr;

  // BURST=1 instance
  logic [LENGTH-1:0] fill_b [4];
  logic [PW-1:0]     pix_in_b;
  logic [3:0]        ack_b;
  logic              rdy_b;
  wire  [3:0]        req_b;
  wire               send_b;
  wire  [PW-1:0]     pix_out_b;
  wire  [1:0]        grant_b;
  wire               busy_b;
  wire               terr_b;

  int errors;
  int checks;

  always #5 clk = ~clk;

  zbuf_pixel_scheduler #(
    .LENGTH(LENGTH), .PIXEL_WIDTH(PW), .BURST(BURST),
    .AGE_MAX(AGE_MAX), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .fill_1(fill[0]), .fill_2(fill[1]), .fill_3(fill[2]), .fill_4(fill[3]),
    .pix_in_1(pix_in[0]), .pix_in_2(pix_in[1]), .pix_in_3(pix_in[2]), .pix_in_4(pix_in[3]),
    .ack_1(ack[0]), .ack_2(ack[1]), .ack_3(ack[2]), .ack_4(ack[3]),
    .req_1(req_w[0]), .req_2(req_w[1]), .req_3(req_w[2]), .req_4(req_w[3]),
    .rdy_z_buffer(rdy), .send_z_buffer(send), .pix_out(pix_out),
    .grant_id(grant_id), .busy(busy), .timeout_err(terr)
  );

  zbuf_pixel_scheduler #(
    .LENGTH(LENGTH), .PIXEL_WIDTH(PW), .BURST(1),
    .AGE_MAX(AGE_MAX), .TIMEOUT(TIMEOUT)
  ) u_dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .fill_1(fill_b[0]), .fill_2(fill_b[1]), .fill_3(fill_b[2]), .fill_4(fill_b[3]),
    .pix_in_1(pix_in_b), .pix_in_2(pix_in_b), .pix_in_3(pix_in_b), .pix_in_4(pix_in_b),
    .ack_1(ack_b[0]), .ack_2(ack_b[1]), .ack_3(ack_b[2]), .ack_4(ack_b[3]),
    .req_1(req_b[0]), .req_2(req_b[1]), .req_3(req_b[2]), .req_4(req_b[3]),
    .rdy_z_buffer(rdy_b), .send_z_buffer(send_b), .pix_out(pix_out_b),
    .grant_id(grant_b), .busy(busy_b), .timeout_err(terr_b)
  );

  // Arbitration rule: starving non-empty source (lowest index), else fullest
  // source with ties to the lowest index.
  function automatic int model_winner(input int f[4], input int a[4]);
    int best;
    best = 0;
    for (int i = 0; i < 4; i++) begin
      if (f[i] != 0 && a[i] == AGE_MAX) return i;
    end
    for (int i = 1; i < 4; i++) begin
      if (f[i] > f[best]) best = i;
    end
    return best;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ack   = 4'b0;
    rdy   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill[i]   = '0;
      pix_in[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_w, send, pix_out, grant_id, busy, terr} !== 17'h0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h, expected 0", {req_w, send, pix_out, grant_id, busy, terr});
    end
    checks++;
    if ({req_b, send_b, busy_b, terr_b} !== 7'h0) begin
      errors++;
      $display("FAIL reset_state_b1: outputs=%h, expected 0", {req_b, send_b, busy_b, terr_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Get FIFO 3 into SEND with the Z-buffer stalled, then pull reset
    fill[2] = 8'd3;
    rdy = 1'b0;
    cyc = 0;
    while (req_w === 4'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (req_w !== 4'b0100) begin
      errors++;
      $display("FAIL reset_setup_req: req=%b, expected 0100", req_w);
    end
    ack[2] = 1'b1; pix_in[2] = 8'h3C;
    @(negedge clk);
    ack[2] = 1'b0;
    checks++;
    if (send !== 1'b1 || pix_out !== 8'h3C) begin
      errors++;
      $display("FAIL reset_setup_send: send=%b pix=%h, expected 1 3c", send, pix_out);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_w, send, pix_out, busy, grant_id} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: req=%b send=%b pix=%h busy=%b grant=%0d, expected all 0",
               req_w, send, pix_out, busy, grant_id);
    end
    fill[2] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_priority();
    int cyc;
    do_reset();
    rdy = 1'b1;
    fill[0] = 8'd3; fill[1] = 8'd9; fill[2] = 8'd9; fill[3] = 8'd1;
    cyc = 0;
    while (req_w === 4'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (req_w !== 4'b0010 || grant_id !== 2'd1 || cyc != 2) begin
      errors++;
      $display("FAIL prio_grant: req=%b grant=%0d after %0d cycles, expected 0010 1 after 2",
               req_w, grant_id, cyc);
    end
    for (int b = 0; b < 4; b++) begin
      ack[1] = 1'b1; pix_in[1] = 8'(8'hB0 + b);
      @(negedge clk);
      ack[1] = 1'b0;
      checks++;
      if (send !== 1'b1 || pix_out !== 8'(8'hB0 + b) || req_w !== 4'b0) begin
        errors++;
        $display("FAIL prio_pixel%0d: send=%b pix=%h req=%b, expected 1 %h 0000",
                 b, send, pix_out, req_w, 8'(8'hB0 + b));
      end
      @(negedge clk);
      if (b < 3) begin
        checks++;
        if (send !== 1'b0 || req_w !== 4'b0010) begin
          errors++;
          $display("FAIL prio_next%0d: send=%b req=%b, expected 0 0010", b, send, req_w);
        end
      end else begin
        checks++;
        if (send !== 1'b0 || req_w !== 4'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL prio_end: send=%b req=%b busy=%b, expected 0 0000 0", send, req_w, busy);
        end
      end
    end
    for (int i = 0; i < 4; i++) fill[i] = '0;
    @(negedge clk);
  endtask

  task automatic test_burst_early_end();
    int cyc;
    do_reset();
    rdy = 1'b1;
    fill[2] = 8'd2;
    cyc = 0;
    while (req_w === 4'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (req_w !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL early_grant: req=%b grant=%0d, expected 0100 2", req_w, grant_id);
    end
    ack[2] = 1'b1; pix_in[2] = 8'hA1;
    @(negedge clk);
    ack[2] = 1'b0; fill[2] = 8'd1;
    checks++;
    if (send !== 1'b1 || pix_out !== 8'hA1) begin
      errors++;
      $display("FAIL early_pix1: send=%b pix=%h, expected 1 a1", send, pix_out);
    end
    @(negedge clk);
    checks++;
    if (send !== 1'b0 || req_w !== 4'b0100) begin
      errors++;
      $display("FAIL early_rereq: send=%b req=%b, expected 0 0100", send, req_w);
    end
    ack[2] = 1'b1; pix_in[2] = 8'hA2;
    @(negedge clk);
    ack[2] = 1'b0; fill[2] = 8'd0;
    checks++;
    if (send !== 1'b1 || pix_out !== 8'hA2) begin
      errors++;
      $display("FAIL early_pix2: send=%b pix=%h, expected 1 a2", send, pix_out);
    end
    @(negedge clk);
    checks++;
    if (send !== 1'b0 || req_w !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_end: send=%b req=%b busy=%b, expected 0 0000 0", send, req_w, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_w !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_empty: req=%b busy=%b, expected 0000 0", req_w, busy);
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    int hi;
    logic bad;
    do_reset();
    fill[0] = 8'd5;
    cyc = 0;
    while (req_w === 4'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    ack[0] = 1'b1; pix_in[0] = 8'h5C;
    @(negedge clk);
    ack[0] = 1'b0; pix_in[0] = 8'h11;
    hi = 0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (send !== 1'b1) break;
      hi++;
      if (pix_out !== 8'h5C || req_w !== 4'b0) bad = 1'b1;
      if (i == 5) begin rdy = 1'b1; fill[0] = '0; end
      @(negedge clk);
    end
    checks++;
    if (hi != 6) begin
      errors++;
      $display("FAIL bp_send_cycles: send high %0d cycles, expected 6", hi);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_stable: pix_out moved or req asserted during stall, expected pix 5c and no req");
    end
    checks++;
    if (busy !== 1'b0 || req_w !== 4'b0) begin
      errors++;
      $display("FAIL bp_end: busy=%b req=%b, expected 0 0000", busy, req_w);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int cnt;
    logic bad;
    do_reset();
    rdy = 1'b1;
    fill[0] = 8'd4;
    cyc = 0;
    while (req_w === 4'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    cnt = 0;
    bad = 1'b0;
    while (req_w[0] === 1'b1 && cnt < 20) begin
      ack[1] = (cnt == 2 || cnt == 3);
      pix_in[1] = 8'h77;
      if (req_w !== 4'b0001 || terr !== 1'b0 || send !== 1'b0) bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
    ack = 4'b0;
    checks++;
    if (cnt != TIMEOUT) begin
      errors++;
      $display("FAIL to_req_cycles: req_1 high %0d cycles, expected %0d", cnt, TIMEOUT);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL to_ignore_ack2: wrong req, early timeout or send seen, expected only req_1");
    end
    checks++;
    if (terr !== 1'b1 || busy !== 1'b0 || send !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: terr=%b busy=%b send=%b, expected 1 0 0", terr, busy, send);
    end
    fill[0] = '0;
    @(negedge clk);
    checks++;
    if (terr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width: terr=%b busy=%b, expected 0 0", terr, busy);
    end
  endtask

  task automatic test_aging();
    int f[4];
    int a[4];
    int w, cyc, last4, n4, maxgap;
    do_reset();
    rdy_b = 1'b1;
    f = '{200, 0, 0, 1};
    a = '{0, 0, 0, 0};
    fill_b[0] = 8'd200; fill_b[3] = 8'd1;
    last4 = 0; n4 = 0; maxgap = 0;
    for (int r = 1; r <= 48; r++) begin
      w = model_winner(f, a);
      for (int i = 0; i < 4; i++) begin
        if (i == w) a[i] = 0;
        else if (f[i] != 0 && a[i] < AGE_MAX) a[i]++;
      end
      cyc = 0;
      while (req_b === 4'b0 && cyc < 12) begin @(negedge clk); cyc++; end
      checks++;
      if (req_b !== (4'b1 << w) || grant_b !== 2'(w)) begin
        errors++;
        $display("FAIL age_round%0d: req=%b grant=%0d, expected %b %0d", r, req_b, grant_b, 4'b1 << w, w);
      end
      if (req_b[3] === 1'b1) begin
        if (r - last4 > maxgap) maxgap = r - last4;
        last4 = r;
        n4++;
      end
      ack_b = req_b; pix_in_b = 8'(r);
      @(negedge clk);
      ack_b = 4'b0;
      checks++;
      if (send_b !== 1'b1 || pix_out_b !== 8'(r)) begin
        errors++;
        $display("FAIL age_send%0d: send=%b pix=%h, expected 1 %h", r, send_b, pix_out_b, 8'(r));
      end
      @(negedge clk);
      checks++;
      if (busy_b !== 1'b0 || send_b !== 1'b0 || terr_b !== 1'b0) begin
        errors++;
        $display("FAIL age_idle%0d: busy=%b send=%b terr=%b, expected 0 0 0", r, busy_b, send_b, terr_b);
      end
    end
    checks++;
    if (n4 != 3 || maxgap > 16 || 48 - last4 >= 16) begin
      errors++;
      $display("FAIL age_starvation: fifo4 grants=%0d maxgap=%0d last=%0d, expected 3 grants gap<=16",
               n4, maxgap, last4);
    end
    fill_b[0] = '0; fill_b[3] = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int mf[4];
    int ma[4];
    int w, cyc, beats, d, s, cnt, o;
    logic [7:0] pv;
    logic bad;
    bit done;
    do_reset();
    for (int i = 0; i < 4; i++) begin mf[i] = 0; ma[i] = 0; end
    for (int r = 0; r < 60; r++) begin
      if (mf[0] + mf[1] + mf[2] + mf[3] == 0) begin
        for (int i = 0; i < 4; i++)
          mf[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
        if ($urandom_range(0, 7) == 0) mf[$urandom_range(0, 3)] = 255;
        if (mf[0] + mf[1] + mf[2] + mf[3] == 0) mf[0] = 1;
        for (int i = 0; i < 4; i++) fill[i] = 8'(mf[i]);
      end
      w = model_winner(mf, ma);
      for (int i = 0; i < 4; i++) begin
        if (i == w) ma[i] = 0;
        else if (mf[i] != 0 && ma[i] < AGE_MAX) ma[i]++;
      end
      cyc = 0;
      while (req_w === 4'b0 && cyc < 10) begin @(negedge clk); cyc++; end
      checks++;
      if (req_w !== (4'b1 << w) || grant_id !== 2'(w)) begin
        errors++;
        $display("FAIL rand_grant%0d: req=%b grant=%0d, expected %b %0d", r, req_w, grant_id, 4'b1 << w, w);
      end
      beats = 0;
      done = 1'b0;
      while (!done) begin
        if ($urandom_range(0, 9) == 0) begin
          // Granted FIFO stays silent while the others chatter on their acks
          cnt = 0;
          bad = 1'b0;
          while (req_w[w] === 1'b1 && cnt < 20) begin
            o = (w + int'($urandom_range(1, 3))) % 4;
            ack = 4'b0;
            ack[o] = 1'($urandom_range(0, 1));
            pix_in[o] = 8'hEE;
            @(negedge clk);
            cnt++;
            if (send !== 1'b0) bad = 1'b1;
          end
          ack = 4'b0;
          checks++;
          if (cnt != TIMEOUT || terr !== 1'b1 || busy !== 1'b0 || bad !== 1'b0) begin
            errors++;
            $display("FAIL rand_timeout%0d: req cycles=%0d terr=%b busy=%b stray send=%b, expected %0d 1 0 0",
                     r, cnt, terr, busy, bad, TIMEOUT);
          end
          done = 1'b1;
        end else begin
          d = int'($urandom_range(0, 3));
          repeat (d) @(negedge clk);
          pv = 8'($urandom);
          ack[w] = 1'b1; pix_in[w] = pv;
          @(negedge clk);
          ack[w] = 1'b0;
          mf[w]--;
          fill[w] = 8'(mf[w]);
          beats++;
          checks++;
          if (send !== 1'b1 || pix_out !== pv || req_w !== 4'b0) begin
            errors++;
            $display("FAIL rand_pixel%0d: send=%b pix=%h req=%b, expected 1 %h 0000", r, send, pix_out, req_w, pv);
          end
          s = int'($urandom_range(0, 3));
          rdy = 1'b0;
          for (int k = 0; k < s; k++) begin
            @(negedge clk);
            checks++;
            if (send !== 1'b1 || pix_out !== pv) begin
              errors++;
              $display("FAIL rand_stall%0d: send=%b pix=%h, expected 1 %h", r, send, pix_out, pv);
            end
          end
          rdy = 1'b1;
          @(negedge clk);
          rdy = 1'b0;
          if (beats < BURST && mf[w] != 0) begin
            checks++;
            if (send !== 1'b0 || req_w !== (4'b1 << w)) begin
              errors++;
              $display("FAIL rand_next%0d: send=%b req=%b, expected 0 %b", r, send, req_w, 4'b1 << w);
            end
          end else begin
            checks++;
            if (send !== 1'b0 || req_w !== 4'b0 || busy !== 1'b0) begin
              errors++;
              $display("FAIL rand_end%0d: send=%b req=%b busy=%b, expected 0 0000 0", r, send, req_w, busy);
            end
            done = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) fill[i] = '0;
    ack = 4'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    rdy      = 1'b0;
    ack      = 4'b0;
    ack_b    = 4'b0;
    rdy_b    = 1'b0;
    pix_in_b = '0;
    for (int i = 0; i < 4; i++) begin
      fill[i]   = '0;
      pix_in[i] = '0;
      fill_b[i] = '0;
    end
    test_reset();
    test_fill_priority();
    test_burst_early_end();
    test_back_pressure();
    test_timeout();
    test_aging();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
